// File: rtl/cal_pkg.sv
// Shared definitions for the cal-tone power averager:
// FSM state encoding and IEEE754 single-precision constants.
package cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    CONVERT,
    PRESENT,
    WAIT_ACK
  } cal_state_e;

  localparam int          FLOAT_BIAS   = 127;
  localparam int          FLOAT_MANT_W = 23;
  localparam logic [31:0] FLOAT_ZERO   = 32'h0;

endpackage

// File: rtl/cal_power_avg_u2f.sv
// u2f_conv: combinational unsigned -> IEEE754 single, exponent reduced by off_i.
// Ports: val_i (IN_W unsigned), off_i (exp offset), f_o (float). Exact for IN_W <= 24.
module u2f_conv
  import cal_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  val_i,
  input  logic [7:0]       off_i,
  output logic [OUT_W-1:0] f_o
);

  localparam int MW1 = FLOAT_MANT_W + 1;

  logic [4:0]     p;
  logic [MW1-1:0] ext;
  logic [MW1-1:0] norm;
  logic [7:0]     exp_f;

  always_comb begin
    p = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (val_i[i]) p = 5'(i);
    end
  end

  assign ext   = MW1'(val_i);
  // Left-justify so the leading one lands on the hidden-bit position.
  assign norm  = ext << (5'(FLOAT_MANT_W) - p);
  assign exp_f = 8'(FLOAT_BIAS) + {3'b0, p} - off_i;

  assign f_o = (val_i == '0) ? OUT_W'(FLOAT_ZERO)
             : OUT_W'({1'b0, exp_f, norm[FLOAT_MANT_W-1:0]});

endmodule

// File: rtl/cal_power_avg.sv
// cal_power_avg: averages 4 cal-tone amplitudes over 2^LOG2_N samples, emits floats
// with a data_valid strobe, then waits for Corr_rdy. Optional: CAL_ACK_TIMEOUT_EN.
module cal_power_avg
  import cal_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SF_WIDTH   = 32,
  parameter int LOG2_N     = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cal_en,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] chA_amp,
  input  logic [DATA_WIDTH-1:0] chB_amp,
  input  logic [DATA_WIDTH-1:0] chC_amp,
  input  logic [DATA_WIDTH-1:0] chD_amp,
  input  logic                  Corr_rdy,
  output logic [SF_WIDTH-1:0]   A_Cal,
  output logic [SF_WIDTH-1:0]   B_Cal,
  output logic [SF_WIDTH-1:0]   C_Cal,
  output logic [SF_WIDTH-1:0]   D_Cal,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  ack_timeout
);

  localparam int AW = DATA_WIDTH + LOG2_N;

  if (AW > 24 || TIMEOUT < 2) begin : g_bad_cfg
    $error("cal_power_avg: unsupported configuration");
  end

  cal_state_e state_q, state_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic [1:0]          ch_q, ch_d;
  logic [AW-1:0]       acc_q [4];
  logic [AW-1:0]       acc_d [4];
  logic [SF_WIDTH-1:0] cal_q [4];
  logic [SF_WIDTH-1:0] cal_d [4];
  logic                dv_q, dv_d;
  logic [DATA_WIDTH-1:0] amp [4];
  logic [SF_WIDTH-1:0] conv_f;

`ifdef CAL_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
  logic          tof_q, tof_d;
`endif

  assign amp[0] = chA_amp;
  assign amp[1] = chB_amp;
  assign amp[2] = chC_amp;
  assign amp[3] = chD_amp;

  u2f_conv #(
    .IN_W  (AW),
    .OUT_W (SF_WIDTH)
  ) u_conv (
    .val_i (acc_q[ch_q]),
    .off_i (8'(LOG2_N)),
    .f_o   (conv_f)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    dv_d    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc_d[i] = acc_q[i];
      cal_d[i] = cal_q[i];
    end
`ifdef CAL_ACK_TIMEOUT_EN
    to_d  = '0;
    tof_d = tof_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        ch_d  = '0;
        for (int i = 0; i < 4; i++) acc_d[i] = '0;
        if (cal_en) state_d = ACCUM;
      end
      ACCUM: begin
        if (!cal_en) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          for (int i = 0; i < 4; i++)
            acc_d[i] = acc_q[i] + AW'(amp[i]);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = CONVERT;
        end
      end
      CONVERT: begin
        cal_d[ch_q] = conv_f;
        ch_d = ch_q + 1'b1;
        if (ch_q == 2'd3) state_d = PRESENT;
      end
      PRESENT: begin
        dv_d    = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (Corr_rdy) state_d = IDLE;
`ifdef CAL_ACK_TIMEOUT_EN
        else if (to_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          tof_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      dv_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
        cal_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      dv_q    <= dv_d;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= acc_d[i];
        cal_q[i] <= cal_d[i];
      end
    end
  end

`ifdef CAL_ACK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q  <= '0;
      tof_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      tof_q <= tof_d;
    end
  end
  assign ack_timeout = tof_q;
`else
  assign ack_timeout = 1'b0;
`endif

  assign A_Cal      = cal_q[0];
  assign B_Cal      = cal_q[1];
  assign C_Cal      = cal_q[2];
  assign D_Cal      = cal_q[3];
  assign data_valid = dv_q;
  assign busy       = (state_q != IDLE);

endmodule
